// File: rtl/masked_gate_hpc1_lanes.sv
`default_nettype none
// ============================================================================
// Module   : masked_gate_hpc1_lanes
// Brief    : Multi-lane masked AND/NAND/OR/NOR gate using the HPC1 gadget.
//            Each lane refreshes b, performs a DOM multiplication and then
//            XOR-compresses the registered terms. NAND/OR/NOR are derived by
//            inverting share 0 of the inputs and/or the product.
// Revision : 1.0 - initial release
// ============================================================================
module masked_gate_hpc1_lanes #(
    parameter int security_order = 2,
    parameter int LANES          = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              in_valid,
    input  logic [1:0]                                        op,
    input  logic [LANES*(security_order+1)-1:0]               ina,
    input  logic [LANES*(security_order+1)-1:0]               inb,
    input  logic [LANES*(security_order+1)*security_order-1:0] rnd,
    output logic                                              out_valid,
    output logic [LANES*(security_order+1)-1:0]               outt
);

    localparam int D        = security_order + 1;
    localparam int RND_REF  = D * (D - 1) / 2;
    localparam int RND_MUL  = D * (D - 1) / 2;
    localparam int RND_LANE = RND_REF + RND_MUL;
    localparam int SW       = LANES * D;
    localparam int TW       = LANES * D * D;

    // Index of pair (i,j), i<j, in the lexicographic pair ordering.
    function automatic int pair_idx(input int i, input int j);
        return i * D - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    // Pipeline state
    logic [SW-1:0] a_d;
    logic [SW-1:0] b_ref;
    logic [TW-1:0] terms;
    logic [1:0]    op_1;
    logic [1:0]    op_2;
    logic          v1;
    logic          v2;

    // Next-state values for each stage
    logic [SW-1:0] a_nxt;
    logic [SW-1:0] b_nxt;
    logic [TW-1:0] term_nxt;
    logic [SW-1:0] out_nxt;

    logic inv_in;
    logic inv_out;

    // OR/NOR invert both operands; NAND/OR invert the product.
    assign inv_in  = op[1];
    assign inv_out = op_2[1] ^ op_2[0];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int RB = l * RND_LANE;

        for (genvar s = 0; s < D; s++) begin : g_share
            logic         b_inv;
            logic [D-1:0] rsel;

            // Only share 0 carries the De Morgan inversion.
            if (s == 0) begin : g_inv
                assign a_nxt[l*D+s] = ina[l*D+s] ^ inv_in;
                assign b_inv        = inb[l*D+s] ^ inv_in;
            end else begin : g_pass
                assign a_nxt[l*D+s] = ina[l*D+s];
                assign b_inv        = inb[l*D+s];
            end

            // Refresh: every pair containing share s contributes its mask bit.
            for (genvar p = 0; p < D; p++) begin : g_ref
                if (p == s) begin : g_self
                    assign rsel[p] = 1'b0;
                end else if (p > s) begin : g_hi
                    assign rsel[p] = rnd[RB + pair_idx(s, p)];
                end else begin : g_lo
                    assign rsel[p] = rnd[RB + pair_idx(p, s)];
                end
            end

            assign b_nxt[l*D+s] = b_inv ^ (^rsel);

            // DOM row s: diagonal product plus masked cross products.
            for (genvar p = 0; p < D; p++) begin : g_term
                if (p == s) begin : g_diag
                    assign term_nxt[(l*D+s)*D+p] = a_d[l*D+s] & b_ref[l*D+p];
                end else if (p > s) begin : g_hi
                    assign term_nxt[(l*D+s)*D+p] = (a_d[l*D+s] & b_ref[l*D+p])
                                                 ^ rnd[RB + RND_REF + pair_idx(s, p)];
                end else begin : g_lo
                    assign term_nxt[(l*D+s)*D+p] = (a_d[l*D+s] & b_ref[l*D+p])
                                                 ^ rnd[RB + RND_REF + pair_idx(p, s)];
                end
            end

            // Compression only after the terms have been registered.
            if (s == 0) begin : g_out_inv
                assign out_nxt[l*D+s] = (^terms[(l*D+s)*D +: D]) ^ inv_out;
            end else begin : g_out_pass
                assign out_nxt[l*D+s] = ^terms[(l*D+s)*D +: D];
            end
        end
    end

    // Stage 1: capture inverted a, refreshed b and op on an accepted transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            a_d   <= '0;
            b_ref <= '0;
            op_1  <= '0;
            v1    <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                a_d   <= a_nxt;
                b_ref <= b_nxt;
                op_1  <= op;
            end
        end
    end

    // Stage 2: register the DOM terms so no compression crosses this boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            terms <= '0;
            op_2  <= '0;
            v2    <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                terms <= term_nxt;
                op_2  <= op_1;
            end
        end
    end

    // Stage 3: registered output shares; hold last value while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            outt      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v2;
            if (v2) begin
                outt <= out_nxt;
            end
        end
    end

endmodule
`default_nettype wire
